// File: rtl/data_deconcat_if.sv
// Byte-in / word-out handshake bundle for the stream unpacker.
// master drives bytes and output-ready; slave is the unpacker.
interface data_deconcat_if #(
  parameter int BW      = 18,
  parameter int N_PRL   = 4,
  parameter int BW_BYTE = 8
);
  logic [BW_BYTE-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [BW-1:0]      y [N_PRL];
  logic               m_valid;
  logic               m_ready;
  logic               err_len;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output m_ready,
    input  s_ready,
    input  y,
    input  m_valid,
    input  err_len
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  m_ready,
    output s_ready,
    output y,
    output m_valid,
    output err_len
  );
endinterface

// File: rtl/data_deconcat.sv
// Byte-stream unpacker: packs N_BYTES bytes MSB-first into N_PRL samples
// held in a one-deep output register with valid/ready.
module data_deconcat #(
  parameter int BW      = 18,
  parameter int N_PRL   = 4,
  parameter int BW_BYTE = 8
) (
  input  logic           clk,
  input  logic           srst_n,
  data_deconcat_if.slave bus
);
  localparam int W       = BW * N_PRL;
  localparam int N_BYTES = W / BW_BYTE;
  localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int AW      = W - BW_BYTE;
  localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

  if ((W % BW_BYTE) != 0 || N_BYTES < 2) begin : g_param_chk
    $error("data_deconcat: BW*N_PRL must be a multiple of BW_BYTE (>=2 bytes)");
  end

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [BW-1:0] r_y [N_PRL];
  logic          r_m_valid;
  logic          r_err_len;

  logic          w_at_last;
  logic          w_stall;
  logic          w_take;
  logic          w_done;
  logic          w_short;
  logic [W-1:0]  w_word;

  assign w_at_last = (r_cnt == LAST);
  // only the word-completing byte can be blocked by a full output
  assign w_stall   = w_at_last & r_m_valid & ~bus.m_ready;
  assign w_take    = bus.s_valid & ~w_stall;
  assign w_done    = w_take & w_at_last;
  assign w_short   = w_take & bus.s_last & ~w_at_last;
  assign w_word    = {r_acc, bus.s_data};

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_done || w_short) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_word[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_m_valid <= 1'b0;
      r_err_len <= 1'b0;
      for (int i = 0; i < N_PRL; i++) begin
        r_y[i] <= '0;
      end
    end else begin
      r_err_len <= w_short;
      if (w_done) begin
        r_m_valid <= 1'b1;
        for (int i = 0; i < N_PRL; i++) begin
          r_y[i] <= w_word[W-1-i*BW -: BW];
        end
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready = ~w_stall;
  assign bus.y       = r_y;
  assign bus.m_valid = r_m_valid;
  assign bus.err_len = r_err_len;

endmodule

// File: tb/tb_data_deconcat.sv
// Self-checking bench for data_deconcat: directed scenarios plus random
// traffic against a byte-queue reference model.
module tb_data_deconcat;
  localparam int BW      = 18;
  localparam int N_PRL   = 4;
  localparam int BW_BYTE = 8;
  localparam int W       = BW * N_PRL;
  localparam int NB      = W / BW_BYTE;

  logic clk;
  logic srst_n;

  data_deconcat_if #(.BW(BW), .N_PRL(N_PRL), .BW_BYTE(BW_BYTE)) bus ();

  data_deconcat #(.BW(BW), .N_PRL(N_PRL), .BW_BYTE(BW_BYTE)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]    bq [$];
  logic [BW-1:0] exp_y [N_PRL];
  logic          exp_valid;
  logic          exp_err;
  logic          last_take;
  int            obs_deliv;
  int            obs_errp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    for (int i = 0; i < N_PRL; i++) exp_y[i] = '0;
  endtask

  task automatic build_word();
    logic [W-1:0] v;
    v = '0;
    foreach (bq[k]) v = (v << 8) | W'(bq[k]);
    for (int i = 0; i < N_PRL; i++)
      exp_y[i] = BW'(v >> (BW * (N_PRL - 1 - i)));
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic l, input logic mr);
    logic exp_sr;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.m_ready = mr;
    #1;
    exp_sr = !(bq.size() == NB - 1 && exp_valid && !mr);
    chk("s_ready", 32'(bus.s_ready), 32'(exp_sr));
    if (bus.m_valid && mr) obs_deliv++;
    last_take = v && exp_sr;
    @(posedge clk);
    if (exp_valid && mr) exp_valid = 1'b0;
    exp_err = 1'b0;
    if (last_take) begin
      if (bq.size() == NB - 1) begin
        bq.push_back(d);
        build_word();
        bq.delete();
        exp_valid = 1'b1;
      end else if (l) begin
        bq.delete();
        exp_err = 1'b1;
      end else begin
        bq.push_back(d);
      end
    end
    #1;
    if (bus.err_len) obs_errp++;
    chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    chk("err_len", 32'(bus.err_len), 32'(exp_err));
    for (int i = 0; i < N_PRL; i++)
      chk($sformatf("y%0d", i), 32'(bus.y[i]), 32'(exp_y[i]));
  endtask

  logic [7:0] tp1 [NB];
  logic [7:0] rb;
  int d0, e0, idx;

  initial begin
    tp1 = '{8'hFF, 8'hFF, 8'hC0, 8'h00, 8'h0A, 8'hAA, 8'hA9, 8'h55, 8'h55};
    obs_deliv = 0;
    obs_errp  = 0;
    last_take = 1'b0;
    model_reset();
    srst_n      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 srst_n = 1'b1;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_err_len", 32'(bus.err_len), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_y0", 32'(bus.y[0]), 32'd0);
    chk("rst_y3", 32'(bus.y[3]), 32'd0);

    // single word
    e0 = obs_errp;
    for (int i = 0; i < NB; i++) step(1'b1, tp1[i], i == NB - 1, 1'b1);
    chk("tp1_valid", 32'(bus.m_valid), 32'd1);
    chk("tp1_y0", 32'(bus.y[0]), 32'h3FFFF);
    chk("tp1_y1", 32'(bus.y[1]), 32'h00000);
    chk("tp1_y2", 32'(bus.y[2]), 32'h2AAAA);
    chk("tp1_y3", 32'(bus.y[3]), 32'h15555);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("tp1_no_err", 32'(obs_errp - e0), 32'd0);

    // back-to-back, four words
    d0 = obs_deliv;
    for (int i = 0; i < 4 * NB; i++)
      step(1'b1, 8'($urandom), i == 4 * NB - 1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("b2b_words", 32'(obs_deliv - d0), 32'd4);

    // backpressure
    for (int i = 0; i < NB; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < NB - 1; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    rb = 8'($urandom);
    for (int i = 0; i < 3; i++) step(1'b1, rb, 1'b0, 1'b0);
    chk("bp_stall", 32'(bus.s_ready), 32'd0);
    step(1'b1, rb, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // short packet then bytes 00..08
    e0 = obs_errp;
    d0 = obs_deliv;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), i == 4, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("short_err_pulses", 32'(obs_errp - e0), 32'd1);
    chk("short_no_word", 32'(obs_deliv - d0), 32'd0);
    for (int i = 0; i < NB; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    chk("seq_y0", 32'(bus.y[0]), 32'h00004);
    chk("seq_y1", 32'(bus.y[1]), 32'h02030);
    chk("seq_y2", 32'(bus.y[2]), 32'h10141);
    chk("seq_y3", 32'(bus.y[3]), 32'h20708);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // reset mid-word with a held output
    for (int i = 0; i < NB; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 srst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mrst_y0", 32'(bus.y[0]), 32'd0);
    chk("mrst_y2", 32'(bus.y[2]), 32'd0);
    #2 srst_n = 1'b1;
    for (int i = 0; i < NB; i++) step(1'b1, tp1[i], 1'b0, 1'b1);
    chk("mrst_y0_after", 32'(bus.y[0]), 32'h3FFFF);
    chk("mrst_y3_after", 32'(bus.y[3]), 32'h15555);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // idle gaps
    idx = 0;
    for (int c = 0; c < 200 && idx < NB; c++) begin
      step(1'($urandom_range(0, 1)), tp1[idx], idx == NB - 1, 1'b1);
      if (last_take) idx++;
    end
    chk("gap_count", 32'(idx), 32'(NB));
    chk("gap_valid", 32'(bus.m_valid), 32'd1);
    chk("gap_y0", 32'(bus.y[0]), 32'h3FFFF);
    chk("gap_y2", 32'(bus.y[2]), 32'h2AAAA);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // random traffic
    for (int c = 0; c < 500; c++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 2) != 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
